// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, format codes and load-FSM state type.
// Used by instr_field_encoder and instr_encoder_loader.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R      = 3'd0,
    FMT_I      = 3'd1,
    FMT_LOAD   = 3'd2,
    FMT_STORE  = 3'd3,
    FMT_BRANCH = 3'd4,
    FMT_JAL    = 3'd5,
    FMT_JALR   = 3'd6,
    FMT_LUI    = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

  // True when v is representable as an nbits-wide two's-complement value.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned nbits);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (nbits - 1));
    return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_encoder.sv
// instr_field_encoder: combinational RV32I field packing with optional
// immediate range check (INSTR_ENC_RANGE_CHECK_EN).
module instr_field_encoder
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [2:0]  func3,
  input  logic        alt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        imm_bad
);

  logic [31:0] raw;
  logic [6:0]  func7;

  always_comb begin
    func7 = alt ? 7'b0100000 : 7'b0000000;
    raw   = NOP_WORD;
    case (fmt)
      FMT_R:      raw = {func7, rs2, rs1, func3, rd, OP_R};
      FMT_I:      raw = {imm[11:0], rs1, func3, rd, OP_I};
      FMT_LOAD:   raw = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
      FMT_STORE:  raw = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
      FMT_BRANCH: raw = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], OP_BRANCH};
      FMT_JAL:    raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      FMT_JALR:   raw = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      FMT_LUI:    raw = {imm[31:12], rd, OP_LUI};
      default:    raw = NOP_WORD;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  always_comb begin
    imm_bad = 1'b0;
    case (fmt)
      FMT_I, FMT_LOAD, FMT_STORE, FMT_JALR: imm_bad = !fits_signed(imm, 12);
      FMT_BRANCH: imm_bad = !fits_signed(imm, 13) || imm[0];
      FMT_JAL:    imm_bad = !fits_signed(imm, 21) || imm[0];
      FMT_LUI:    imm_bad = |imm[11:0];
      default:    imm_bad = 1'b0;
    endcase
  end

  // A rejected immediate still occupies its slot, as a harmless NOP.
  assign word = imm_bad ? NOP_WORD : raw;
`else
  logic unused_imm_lsb;

  assign imm_bad        = 1'b0;
  assign word           = raw;
  assign unused_imm_lsb = imm[0];
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams encoded RV32I words into instruction memory under a small load FSM.
// Optional immediate range check: define INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_fmt,
  input  logic [2:0]        req_func3,
  input  logic              req_alt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err,
  output logic              ovf
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  load_state_e       state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              xfer;
  logic              start_ok;
  logic              at_top;
  logic [31:0]       enc_word;
  logic              enc_bad;

  instr_field_encoder u_enc (
    .fmt     (req_fmt),
    .func3   (req_func3),
    .alt     (req_alt),
    .rd      (req_rd),
    .rs1     (req_rs1),
    .rs2     (req_rs2),
    .imm     (req_imm),
    .word    (enc_word),
    .imm_bad (enc_bad)
  );

  assign at_top = (addr == ADDR_MAX);
  assign xfer   = req_valid && req_ready;
  assign busy   = (state == ST_LOAD);
  assign done   = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    start_ok  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        start_ok = start;
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        req_ready = 1'b1;
        // Last word at the top address ends the load rather than wrapping.
        if (req_valid && (req_last || at_top)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      ovf        <= 1'b0;
    end else begin
      imem_we <= xfer;
      if (start_ok) begin
        addr       <= start_addr;
        word_count <= '0;
        ovf        <= 1'b0;
      end else if (xfer) begin
        imem_addr  <= addr;
        imem_wdata <= enc_word;
        word_count <= word_count + (ADDR_W + 1)'(1);
        if (!at_top) addr <= addr + ADDR_W'(1);
        if (at_top && !req_last) ovf <= 1'b1;
      end
    end
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err <= 1'b0;
    else if (start_ok)         err <= 1'b0;
    else if (xfer && enc_bad)  err <= 1'b1;
  end
`else
  logic unused_enc_bad;

  assign err            = 1'b0;
  assign unused_enc_bad = enc_bad;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encoding table plus load-FSM
// corner sequences (overflow on a 2-bit-address instance, async reset).
module tb_instr_encoder_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  start_addr;
  logic        req_valid;
  logic [2:0]  req_fmt;
  logic [2:0]  req_func3;
  logic        req_alt;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        req_last;

  logic        req_ready, imem_we, busy, done, err, ovf;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  word_count;

  logic        req_ready_b, imem_we_b, busy_b, done_b, err_b, ovf_b;
  logic [1:0]  imem_addr_b;
  logic [31:0] imem_wdata_b;
  logic [2:0]  word_count_b;

  int n_checks = 0;
  int n_fail   = 0;

  instr_encoder_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
    .req_func3(req_func3), .req_alt(req_alt), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .req_last(req_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done),
    .word_count(word_count), .err(err), .ovf(ovf)
  );

  instr_encoder_loader #(.ADDR_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr[1:0]),
    .req_valid(req_valid), .req_ready(req_ready_b), .req_fmt(req_fmt),
    .req_func3(req_func3), .req_alt(req_alt), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .req_last(req_last), .imem_we(imem_we_b), .imem_addr(imem_addr_b),
    .imem_wdata(imem_wdata_b), .busy(busy_b), .done(done_b),
    .word_count(word_count_b), .err(err_b), .ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] a);
    start = 1'b1;
    start_addr = a;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ready_after_start", 32'(req_ready), 32'd1);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("done_after_start", 32'(done), 32'd0);
    chk("count_after_start", 32'(word_count), 32'd0);
  endtask

  task automatic send(input logic [2:0] f, input logic [2:0] f3, input logic alt,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic last);
    req_valid = 1'b1;
    req_fmt = f; req_func3 = f3; req_alt = alt;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
    req_imm = imm; req_last = last;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,        32'h002081B3};
    vecs[1]  = '{3'd0, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 32'd0,        32'h407302B3};
    vecs[2]  = '{3'd3, 3'd5, 1'b0, 5'd9, 5'd1, 5'd2, 32'd8,        32'h0020A423};
    vecs[3]  = '{3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3};
    vecs[4]  = '{3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,        32'h008000EF};
    vecs[5]  = '{3'd1, 3'd0, 1'b1, 5'd1, 5'd2, 5'd31, 32'hFFFFFFFF, 32'hFFF10093};
    vecs[6]  = '{3'd2, 3'd0, 1'b0, 5'd4, 5'd2, 5'd0, 32'd16,       32'h01012203};
    vecs[7]  = '{3'd6, 3'd7, 1'b0, 5'd1, 5'd5, 5'd0, 32'd4,        32'h004280E7};
    vecs[8]  = '{3'd7, 3'd0, 1'b0, 5'd6, 5'd9, 5'd0, 32'h12345000, 32'h12345337};
    vecs[9]  = '{3'd0, 3'd7, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0,        32'h003170B3};
    vecs[10] = '{3'd5, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8, 32'hFF9FF06F};
    vecs[11] = '{3'd4, 3'd1, 1'b0, 5'd0, 5'd3, 5'd4, 32'd16,       32'h00419863};

    rst_n = 1'b0; start = 1'b0; start_addr = '0; req_valid = 1'b0;
    req_fmt = '0; req_func3 = '0; req_alt = 1'b0; req_rd = '0;
    req_rs1 = '0; req_rs2 = '0; req_imm = '0; req_last = 1'b0;

    #12;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(req_ready), 32'd0);

    // single R-type, last
    do_start(8'd0);
    send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    chk("t1_we", 32'(imem_we), 32'd1);
    chk("t1_addr", 32'(imem_addr), 32'd0);
    chk("t1_wdata", imem_wdata, 32'h002081B3);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_count", 32'(word_count), 32'd1);

    // restart coincident with the final write; SUB then STORE back-to-back
    do_start(8'd0);
    chk("t2_prev_done_cleared", 32'(done), 32'd0);
    send(3'd0, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0);
    chk("t2_sub_wdata", imem_wdata, 32'h407302B3);
    chk("t2_sub_addr", 32'(imem_addr), 32'd0);
    send(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1);
    chk("t2_st_we", 32'(imem_we), 32'd1);
    chk("t2_st_wdata", imem_wdata, 32'h0020A423);
    chk("t2_st_addr", 32'(imem_addr), 32'd1);
    chk("t2_count", 32'(word_count), 32'd2);
    @(posedge clk); #1;
    chk("t2_we_idle", 32'(imem_we), 32'd0);
    chk("t2_done_held", 32'(done), 32'd1);

    // encoding table streamed at one word per cycle from 0x10
    do_start(8'h10);
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].fmt, vecs[i].f3, vecs[i].alt, vecs[i].rd, vecs[i].rs1,
           vecs[i].rs2, vecs[i].imm, (i == NV - 1));
      chk($sformatf("vec%0d_wdata", i), imem_wdata, vecs[i].exp);
      chk($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'h10 + 32'(i));
      chk($sformatf("vec%0d_we", i), 32'(imem_we), 32'd1);
      chk($sformatf("vec%0d_count", i), 32'(word_count), 32'(i + 1));
      chk($sformatf("vec%0d_done", i), 32'(done), (i == NV - 1) ? 32'd1 : 32'd0);
    end
    chk("tbl_ovf", 32'(ovf), 32'd0);

    // out-of-range immediate
    do_start(8'h30);
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    chk("rng_wdata", imem_wdata, 32'h00000013);
    chk("rng_err", 32'(err), 32'd1);
`else
    chk("rng_wdata", imem_wdata, 32'h80000093);
    chk("rng_err", 32'(err), 32'd0);
`endif
    chk("rng_addr", 32'(imem_addr), 32'h30);
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b1);
    chk("rng_next_addr", 32'(imem_addr), 32'h31);
    chk("rng_next_wdata", imem_wdata, 32'h00100093);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    chk("rng_err_sticky", 32'(err), 32'd1);
`endif
    do_start(8'h40);
    chk("rng_err_cleared", 32'(err), 32'd0);
    send(3'd0, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1);

    // overflow on the 2-bit-address instance: five non-last requests held valid
    do_start(8'd0);
    chk("ovf_small_ready0", 32'(req_ready_b), 32'd1);
    req_valid = 1'b1; req_fmt = 3'd0; req_func3 = 3'd0; req_alt = 1'b0;
    req_rd = 5'd1; req_rs1 = 5'd1; req_rs2 = 5'd1; req_imm = '0; req_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k < 4) begin
        chk($sformatf("ovf_we%0d", k), 32'(imem_we_b), 32'd1);
        chk($sformatf("ovf_addr%0d", k), 32'(imem_addr_b), 32'(k));
      end else begin
        chk("ovf_fifth_not_taken", 32'(imem_we_b), 32'd0);
      end
      chk($sformatf("ovf_flag%0d", k), 32'(ovf_b), (k >= 3) ? 32'd1 : 32'd0);
      chk($sformatf("ovf_done%0d", k), 32'(done_b), (k >= 3) ? 32'd1 : 32'd0);
      chk($sformatf("ovf_ready%0d", k), 32'(req_ready_b), (k >= 3) ? 32'd0 : 32'd1);
    end
    chk("ovf_small_count", 32'(word_count_b), 32'd4);
    chk("ovf_big_flag", 32'(ovf), 32'd0);
    chk("ovf_big_busy", 32'(busy), 32'd1);
    chk("ovf_big_count", 32'(word_count), 32'd5);

    // start while loading is ignored: next word continues at address 5
    start = 1'b1; start_addr = 8'h40;
    @(posedge clk); #1;
    start = 1'b0; req_valid = 1'b0;
    chk("ign_start_addr", 32'(imem_addr), 32'd5);
    chk("ign_start_count", 32'(word_count), 32'd6);

    // asynchronous reset mid-load
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    chk("mid_rst_wdata", imem_wdata, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_count", 32'(word_count), 32'd0);
    chk("mid_rst_ovf_small", 32'(ovf_b), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(busy), 32'd0);
    do_start(8'd7);
    send(3'd7, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'hABCDE000, 1'b1);
    chk("reload_addr", 32'(imem_addr), 32'd7);
    chk("reload_wdata", imem_wdata, 32'hABCDE137);
    chk("reload_count", 32'(word_count), 32'd1);
    chk("reload_done", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

- Encoder direction of the control decoder: it takes decoded instruction fields (format, func3, alt bit, registers, immediate) and produces RV32I instruction words.
- It writes those words sequentially into instruction memory over a word-addressed write port.
- It is used to load test programs and self-generated code before the single-cycle core runs.
- Requests arrive over a valid/ready handshake; the block runs a small load FSM with an address counter, completion status and overflow status.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width (depth 2^ADDR_W words)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a load at start_addr (honoured in IDLE/DONE only)
- start_addr  in  ADDR_W  first word address
- req_valid  in  1  request valid
- req_ready  out  1  block can accept a request
- req_fmt  in  3  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI
- req_func3  in  3  func3 field
- req_alt  in  1  R-type only: 1 selects func7=0100000 (SUB), else 0000000
- req_rd / req_rs1 / req_rs2  in  5 each  register indices
- req_imm  in  32  immediate, sign-extended byte offset (LUI: full 32-bit value)
- req_last  in  1  marks final request of the program
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  write word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  FSM not in IDLE/DONE
- done  out  1  load finished (held until next start)
- word_count  out  ADDR_W+1  words written since last start
- err  out  1  sticky; an immediate failed its range check
- ovf  out  1  sticky; address space exhausted before req_last

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE→LOAD on start: addr←start_addr, word_count←0, err←0, ovf←0, done←0.
  - LOAD: req_ready = 1 while no overflow is pending.
    - A transfer occurs when req_valid && req_ready.
    - A transfer with req_last goes to DONE.
    - A transfer at addr = 2^ADDR_W−1 without req_last sets ovf and goes to DONE.
  - DONE→LOAD on start, with the same initialisation as IDLE→LOAD.
- start in LOAD is ignored.
- Encoding:
  - R: {func7, rs2, rs1, f3, rd, 0110011}
  - I-ALU: {imm[11:0], rs1, f3, rd, 0010011}
  - LOAD: {imm[11:0], rs1, 010, rd, 0000011}; f3 is forced to 010.
  - STORE: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}
  - JALR: {imm[11:0], rs1, 000, rd, 1100111}
  - LUI: {imm[31:12], rd, 0110111}
- Unused fields per format are ignored.
- Address arithmetic is unsigned ADDR_W bits. The address never wraps; overflow ends the load instead.
- Reset mid-load aborts the load; the memory contents already written are not reverted.

## Timing
- Reset values: req_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, word_count 0, err 0, ovf 0. State resets to IDLE.
- Latency is one cycle: a transfer on edge N drives imem_we=1, imem_addr, imem_wdata (all registered) during cycle N+1.
- Throughput is one word per cycle.
- req_ready is registered-state combinational; it is 1 in the first cycle after start.
- word_count increments together with each imem_we.
- done and busy update with the state register.
  - done rises in the cycle the final imem_we is driven.
  - busy falls in that same cycle.
- start coincident with the final write in DONE is legal; the write completes first.

## Configuration
- INSTR_ENC_RANGE_CHECK_EN defined:
  - Immediates are range-checked per format:
    - I-ALU / LOAD / STORE / JALR: signed 12-bit.
    - BRANCH: signed 13-bit with bit 0 clear.
    - JAL: signed 21-bit with bit 0 clear.
    - LUI: imm[11:0] = 0.
  - A failure sets err and writes NOP 0x00000013 in place of the encoded word. The address still advances.
- Undefined: no checking, err is tied 0, and out-of-range bits are silently truncated.

## Structure
- Shared package riscv_pkg holds:
  - fmt codes FMT_R … FMT_LUI;
  - opcode constants OP_R 0110011, OP_I 0010011, OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011, OP_JAL 1101111, OP_JALR 1100111, OP_LUI 0110111;
  - NOP_WORD 0x00000013;
  - FSM state typedef.
- Sub-module instr_field_encoder: purely combinational field packing plus range check (output word and imm_bad). The top holds the FSM, address and count registers, and the output registers.

## Test plan
- start_addr 0; R f3 000 alt0 rd3 rs1 1 rs2 2, last → wdata 0x002081B3 at addr 0 one cycle later, done=1, word_count=1.
- Back-to-back R SUB rd5 rs1 6 rs2 7, then STORE rs1 1 rs2 2 imm 8 (last) → 0x407302B3 @0, 0x0020A423 @1 on consecutive cycles.
- BRANCH f3 000 rs1 1 rs2 2 imm −4, then JAL rd1 imm 8 (last) → 0xFE208EE3, 0x008000EF.
- With INSTR_ENC_RANGE_CHECK_EN: I-ALU imm 2048 → err=1, wdata 0x00000013, address still advances.
- ADDR_W=2, start_addr 0, five non-last requests held valid → writes at 0..3, ovf=1, done=1, fifth not accepted (req_ready 0).
- rst_n low during LOAD after 2 writes → all outputs 0 immediately, IDLE; a new start reloads from start_addr with word_count=0.
